// File: rtl/irq_sequencer.sv
// Interrupt/exception sequencer for the single-cycle MIPS core: captures and masks
// peripheral requests, arbitrates against undefined-instruction exceptions, tracks handler service.
module irq_sequencer #(
  parameter int unsigned N_IRQ = 4,
  parameter int unsigned WDOG  = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic             pc_high,
  input  logic             exc_undef,
  input  logic             cfg_we,
  input  logic [N_IRQ-1:0] cfg_mask,
  output logic             Interrupt,
  output logic             Exception,
  output logic [3:0]       cause,
  output logic [N_IRQ-1:0] irq_ack,
  output logic             busy,
  output logic             fault
);

  localparam int unsigned WDW = $clog2(WDOG + 1);

  typedef enum logic [2:0] {IDLE, ENTRY, WAIT_K, IN_K, GUARD} state_t;

  state_t           state, state_n;
  logic [N_IRQ-1:0] src_q, pending, mask, req, win_oh;
  logic [2:0]       win_idx;
  logic [WDW-1:0]   wd_cnt, wd_cnt_n;
  logic             take_irq, wd_expire, fault_set;

  assign req    = pending & mask;
  // Isolate the lowest set request bit for the one-hot acknowledge.
  assign win_oh = req & (~req + N_IRQ'(1));

  always_comb begin
    win_idx = '0;
    for (int unsigned i = N_IRQ; i > 0; i--) begin
      if (req[i-1]) win_idx = 3'(i - 1);
    end
  end

  // Gated by reset so the output drops asynchronously along with the registers.
  assign Exception = reset & exc_undef & ~pc_high & (state == IDLE) & ~fault;
  assign busy      = (state != IDLE);
  assign fault_set = (exc_undef & pc_high) | wd_expire;

  always_comb begin
    state_n   = state;
    wd_cnt_n  = '0;
    take_irq  = 1'b0;
    wd_expire = 1'b0;
    case (state)
      IDLE: begin
        if (Exception) begin
          state_n = WAIT_K;
        end else if (!fault && !pc_high && (|req)) begin
          take_irq = 1'b1;
          state_n  = ENTRY;
        end
      end
      ENTRY:  state_n = WAIT_K;
      WAIT_K: begin
        if (pc_high) begin
          state_n = IN_K;
        end else if (wd_cnt == WDW'(WDOG - 1)) begin
          wd_expire = 1'b1;
          state_n   = IDLE;
        end else begin
          wd_cnt_n = wd_cnt + 1'b1;
        end
      end
      IN_K:    if (!pc_high) state_n = GUARD;
      GUARD:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wd_cnt    <= '0;
      src_q     <= '0;
      pending   <= '0;
      mask      <= '1;
      Interrupt <= 1'b0;
      irq_ack   <= '0;
      cause     <= '0;
      fault     <= 1'b0;
    end else begin
      state     <= state_n;
      wd_cnt    <= wd_cnt_n;
      src_q     <= irq_src;
      // New edges are OR-ed in after the acknowledge clear, so a set wins.
      pending   <= (pending & ~irq_ack) | (irq_src & ~src_q);
      if (cfg_we) mask <= cfg_mask;
      Interrupt <= take_irq;
      irq_ack   <= take_irq ? win_oh : '0;
      if (take_irq)       cause <= {1'b0, win_idx};
      else if (Exception) cause <= 4'b1000;
      if (fault_set) fault <= 1'b1;
    end
  end

endmodule
